// File: rtl/vr_vc_converter.sv
// vr_vc_converter
//   Sender end of a credit link. Takes a valid/ready stream from upstream and
//   drives a valid/credit stream downstream. A credit counter tracks how many
//   free slots the downstream receiver's buffer still has.
//
//   Ports
//     clk, rst       clock and synchronous active-high reset
//     s_data_i       upstream payload
//     s_valid_i      upstream valid
//     s_ready_o      upstream ready; asserted only while a credit is held
//     m_data_o       downstream payload (registered, held between beats)
//     m_valid_o      downstream valid (registered, one cycle per beat)
//     m_credit_i     credit return; each cycle it is high returns one credit
//     credit_cnt_o   current credit count, for debug
//     idle_o         all credits are home and no beat is in flight
//     credit_err_o   sticky flag; set when a credit arrives with the counter full
module vr_vc_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2,
    localparam int CW = $clog2(CREDIT_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_credit_i,
    output logic [CW-1:0]         credit_cnt_o,
    output logic                  idle_o,
    output logic                  credit_err_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  err_q, err_d;
    logic                  acc;

    // Ready decodes the counter register only, so upstream never sees a
    // combinational path from the credit return or its own valid.
    assign s_ready_o = (cnt_q != '0);
    assign acc       = s_valid_i && s_ready_o;

    always_comb begin
        cnt_d     = cnt_q;
        m_valid_d = acc;
        m_data_d  = m_data_q;
        err_d     = err_q;

        if (acc) begin
            m_data_d = s_data_i;
        end

        // Credit and accept in the same cycle cancel. A credit with the
        // counter already full and nothing leaving is an overflow: the count
        // saturates and the error flag sticks until reset.
        if (m_credit_i && !acc) begin
            if (cnt_q == CNT_MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!m_credit_i && acc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign credit_cnt_o = cnt_q;
    assign credit_err_o = err_q;
    assign idle_o       = (cnt_q == CNT_MAX) && !m_valid_q;

endmodule

// File: tb/tb_vr_vc_converter.sv
// tb_vr_vc_converter
//   Directed bench for vr_vc_converter at default parameters
//   (DATA_WIDTH = 8, CREDIT_NUM = 2). Inputs change 1 ns after a rising edge
//   and outputs are checked at that same point, so every check sees the
//   state produced by the preceding edge.
module tb_vr_vc_converter;

    logic       clk;
    logic       rst;
    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_credit_i;
    logic [1:0] credit_cnt_o;
    logic       idle_o;
    logic       credit_err_o;

    int n_chk;
    int n_err;

    vr_vc_converter #(
        .DATA_WIDTH(8),
        .CREDIT_NUM(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_credit_i  (m_credit_i),
        .credit_cnt_o(credit_cnt_o),
        .idle_o      (idle_o),
        .credit_err_o(credit_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full set of observable outputs in one go.
    task automatic chk_all(input string tag, input logic rdy, input logic vld,
                           input logic [7:0] dat, input logic [1:0] cnt,
                           input logic idl, input logic err);
        chk({tag, ".ready"}, 32'(s_ready_o), 32'(rdy));
        chk({tag, ".valid"}, 32'(m_valid_o), 32'(vld));
        chk({tag, ".data"},  32'(m_data_o),  32'(dat));
        chk({tag, ".cnt"},   32'(credit_cnt_o), 32'(cnt));
        chk({tag, ".idle"},  32'(idle_o), 32'(idl));
        chk({tag, ".err"},   32'(credit_err_o), 32'(err));
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b1;
        s_valid_i  = 1'b1;
        s_data_i   = 8'hA5;
        m_credit_i = 1'b0;

        // 1. reset, then startup with upstream already waiting
        repeat (3) tick();
        chk_all("rst", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("init", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("init_hold", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        s_valid_i  = 1'b0;
        m_credit_i = 1'b1;
        tick();
        chk_all("cred1", 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0);
        tick();
        m_credit_i = 1'b0;
        chk_all("cred2", 1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0);

        // 2. single beat
        s_valid_i = 1'b1;
        s_data_i  = 8'h3C;
        tick();
        s_valid_i = 1'b0;
        chk_all("beat", 1'b1, 1'b1, 8'h3C, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("beat_end", 1'b1, 1'b0, 8'h3C, 2'd1, 1'b0, 1'b0);
        m_credit_i = 1'b1;
        tick();
        m_credit_i = 1'b0;
        chk("beat_ret.cnt", 32'(credit_cnt_o), 32'd2);

        // 3. credit exhaustion
        s_valid_i = 1'b1;
        s_data_i  = 8'h01;
        tick();
        chk_all("exh1", 1'b1, 1'b1, 8'h01, 2'd1, 1'b0, 1'b0);
        s_data_i = 8'h02;
        tick();
        chk_all("exh2", 1'b0, 1'b1, 8'h02, 2'd0, 1'b0, 1'b0);
        s_data_i = 8'h03;
        tick();
        chk_all("exh_stall", 1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 1'b0);
        m_credit_i = 1'b1;
        tick();
        m_credit_i = 1'b0;
        chk_all("exh_cred", 1'b1, 1'b0, 8'h02, 2'd1, 1'b0, 1'b0);
        tick();
        s_valid_i = 1'b0;
        chk_all("exh3", 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 1'b0);

        // 4. simultaneous credit and accept, 10 beats at full rate
        m_credit_i = 1'b1;
        tick();
        chk("sim_pre.cnt", 32'(credit_cnt_o), 32'd1);
        s_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data_i = 8'h10 + 8'(i);
            tick();
            chk($sformatf("sim%0d.valid", i), 32'(m_valid_o), 32'd1);
            chk($sformatf("sim%0d.data", i),  32'(m_data_o),  32'(8'h10 + 8'(i)));
            chk($sformatf("sim%0d.cnt", i),   32'(credit_cnt_o), 32'd1);
            chk($sformatf("sim%0d.ready", i), 32'(s_ready_o), 32'd1);
        end
        s_valid_i = 1'b0;
        tick();
        m_credit_i = 1'b0;
        chk_all("sim_drain", 1'b1, 1'b0, 8'h19, 2'd2, 1'b1, 1'b0);

        // 5. overflow, sticky through further traffic
        m_credit_i = 1'b1;
        tick();
        m_credit_i = 1'b0;
        chk_all("ovf", 1'b1, 1'b0, 8'h19, 2'd2, 1'b1, 1'b1);
        s_valid_i = 1'b1;
        s_data_i  = 8'h55;
        tick();
        s_valid_i = 1'b0;
        chk_all("ovf_beat", 1'b1, 1'b1, 8'h55, 2'd1, 1'b0, 1'b1);
        m_credit_i = 1'b1;
        tick();
        m_credit_i = 1'b0;
        chk_all("ovf_ret", 1'b1, 1'b0, 8'h55, 2'd2, 1'b1, 1'b1);

        // 6. reset mid-stream with a credit arriving during reset
        s_valid_i = 1'b1;
        s_data_i  = 8'h66;
        tick();
        s_data_i  = 8'h77;
        tick();
        chk_all("mid", 1'b0, 1'b1, 8'h77, 2'd0, 1'b0, 1'b1);
        rst        = 1'b1;
        m_credit_i = 1'b1;
        tick();
        chk_all("mid_rst", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst        = 1'b0;
        m_credit_i = 1'b0;
        tick();
        chk_all("post_rst", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
